// File: rtl/wb_uart_rx.sv
// DL11-style serial receiver on a Wishbone slave port: RCSR (DONE/IE) and RBUF (ERR/OR/FE/data).
// 8N1 input is sampled on a 16x oversample tick; irq is a registered DONE & IE.
module wb_uart_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DIV    = CLK_HZ / (16 * BAUD)
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic        wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        rxd,
    output logic        irq
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TRELOAD = TW'(DIV - 1);
    localparam logic [TW-1:0] TONE    = TW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          r_sync1, r_sync2;
    logic [TW-1:0] r_tcnt;
    logic [3:0]    r_sc;
    logic [2:0]    r_bcnt;
    logic [2:0]    r_state;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_fe, r_or, r_done, r_ie;
    logic          r_ack, r_irq;
    logic [15:0]   r_dat;

    logic          w_rx_s, w_tick, w_mid, w_end, w_load, w_start;
    logic          w_req, w_rbuf_read, w_ie_wr;
    logic [15:0]   w_rd_val;
    logic          w_unused;

    assign w_rx_s  = r_sync2;
    assign w_tick  = (r_tcnt == '0);
    assign w_mid   = w_tick && (r_sc == 4'd6);
    assign w_end   = w_tick && (r_sc == 4'd14);
    assign w_start = (r_state == S_IDLE) && !w_rx_s;
    assign w_load  = (r_state == S_STOP) && w_end;

    assign w_req       = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_rbuf_read = w_req & ~wb_we_i & wb_adr_i;
    assign w_ie_wr     = w_req & wb_we_i & ~wb_adr_i & wb_sel_i[0];
    assign w_rd_val    = wb_adr_i ? {r_or | r_fe, r_or, r_fe, 5'b0, r_data}
                                  : {8'b0, r_done, r_ie, 6'b0};
    assign w_unused    = ^{wb_sel_i[1], wb_dat_i[15:7], wb_dat_i[5:0]};

    assign wb_dat_o = r_dat;
    assign wb_ack_o = r_ack;
    assign irq      = r_irq;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running tick, re-phased on each start edge so sampling tracks the frame.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n)
            r_tcnt <= '0;
        else if (w_start || w_tick)
            r_tcnt <= TRELOAD;
        else
            r_tcnt <= r_tcnt - TONE;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= S_IDLE;
            r_sc    <= 4'd0;
            r_bcnt  <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            if (w_tick)
                r_sc <= r_sc + 4'd1;
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_sc    <= 4'd0;
                    end
                end
                S_START: begin
                    if (w_mid) begin
                        if (!w_rx_s) begin
                            r_state <= S_DATA;
                            r_sc    <= 4'd0;
                            r_bcnt  <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (w_end) begin
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_bcnt  <= r_bcnt + 3'd1;
                        if (r_bcnt == 3'd7)
                            r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_end)
                        r_state <= w_rx_s ? S_IDLE : S_BREAK;
                end
                S_BREAK: begin
                    if (w_rx_s)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A load on the same clock as an RBUF read wins: DONE stays set, no overrun.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_data <= 8'd0;
            r_fe   <= 1'b0;
            r_or   <= 1'b0;
            r_done <= 1'b0;
        end else if (w_load) begin
            r_data <= r_shift;
            r_fe   <= ~w_rx_s;
            r_or   <= r_done & ~w_rbuf_read;
            r_done <= 1'b1;
        end else if (w_rbuf_read) begin
            r_done <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_ack <= 1'b0;
            r_dat <= 16'd0;
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_irq <= r_done & r_ie;
            if (w_req)
                r_dat <= w_rd_val;
            if (w_ie_wr)
                r_ie <= wb_dat_i[6];
        end
    end

endmodule

// File: tb/tb_wb_uart_rx.sv
// Bench for wb_uart_rx: directed serial frames on rxd, bus reads scored by an ack-driven monitor.
`timescale 1ns/1ps
module tb_wb_uart_rx;

    localparam int CLK_NS = 20;
    localparam int BIT_NS = 8680;
    localparam int DIV    = 27;
    // Clocks from the first posedge after the start edge to the STOP load edge:
    // 2 sync + 1 IDLE decision, then 150 ticks of DIV clocks.
    localparam int LOAD_EDGE = 3 + 150 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, adr = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [15:0] dat_i = 16'h0000;
    logic [15:0] dat_o;
    logic        ack;
    logic        rxd = 1'b1;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];
    string       nm_q[$];

    wb_uart_rx #(.CLK_HZ(50000000), .BAUD(115200)) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_we_i(we), .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .rxd(rxd), .irq(irq)
    );

    always #(CLK_NS/2) clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack && !we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_read_ack got %h expected none", dat_o);
            end else begin
                automatic logic [15:0] e = exp_q.pop_front();
                automatic string n = nm_q.pop_front();
                chk(n, dat_o, e);
            end
        end
    end

    task automatic bus(input logic w, input logic a, input logic [1:0] s, input logic [15:0] d);
        int t;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        t = 0;
        @(negedge clk);
        while (!ack && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!ack) begin
            n_checks++;
            n_errors++;
            $display("FAIL ack_timeout got 0 expected 1");
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic a, input logic [15:0] e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        bus(1'b0, a, 2'b00, 16'h0000);
    endtask

    task automatic wr(input logic a, input logic [1:0] s, input logic [15:0] d);
        bus(1'b1, a, s, d);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        @(posedge clk); #1;
        rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(BIT_NS);
        end
        rxd = stop;
        #(BIT_NS);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {15'b0, ack}, 16'h0000);
        chk("rst_dat", dat_o, 16'h0000);
        chk("rst_irq", {15'b0, irq}, 16'h0000);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // reset mid-frame, then a clean byte
        @(posedge clk); #1;
        rxd = 1'b0; #(BIT_NS);
        rxd = 1'b1; #(BIT_NS);
        rxd = 1'b0; #(BIT_NS/2);
        rst_n = 1'b0;
        #100; rxd = 1'b1; #100;
        chk("midrst_irq", {15'b0, irq}, 16'h0000);
        chk("midrst_dat", dat_o, 16'h0000);
        rst_n = 1'b1;
        #(2*BIT_NS);
        send(8'h55, 1'b1);
        rd(1'b0, 16'h0080, "t1_rcsr");
        rd(1'b1, 16'h0055, "t1_rbuf");
        chk("t1_irq", {15'b0, irq}, 16'h0000);
        rd(1'b0, 16'h0000, "t1_rcsr_cleared");

        // interrupt path with exact irq timing around the STOP load
        wr(1'b0, 2'b01, 16'h0040);
        rd(1'b0, 16'h0040, "t2_ie_set");
        fork
            send(8'hA3, 1'b1);
            begin
                @(negedge rxd);
                repeat (LOAD_EDGE) @(posedge clk);
                #1;
                chk("t2_irq_lags_done", {15'b0, irq}, 16'h0000);
                @(posedge clk); #1;
                chk("t2_irq_rise", {15'b0, irq}, 16'h0001);
            end
        join
        rd(1'b0, 16'h00C0, "t2_rcsr");
        rd(1'b1, 16'h00A3, "t2_rbuf");
        chk("t2_irq_fall", {15'b0, irq}, 16'h0000);
        rd(1'b0, 16'h0040, "t2_rcsr_after");
        wr(1'b0, 2'b10, 16'h0000);
        rd(1'b0, 16'h0040, "t2_sel_hi_ignored");
        wr(1'b0, 2'b01, 16'h0000);
        rd(1'b0, 16'h0000, "t2_ie_clr");
        wr(1'b1, 2'b11, 16'hFFFF);
        rd(1'b1, 16'h00A3, "t2_rbuf_wr_ignored");

        // overrun
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        rd(1'b0, 16'h0080, "t3_rcsr");
        rd(1'b1, 16'hC022, "t3_overrun");
        rd(1'b0, 16'h0000, "t3_rcsr_cleared");
        rd(1'b1, 16'hC022, "t3_rbuf_held");

        // framing error into break, then recovery
        send(8'h7E, 1'b0);
        #(20*BIT_NS);
        rd(1'b0, 16'h0080, "t4_rcsr");
        rd(1'b1, 16'hA07E, "t4_fe");
        rxd = 1'b1;
        #(BIT_NS);
        send(8'h01, 1'b1);
        rd(1'b1, 16'h0001, "t4_after_break");

        // glitch reject
        @(posedge clk); #1;
        rxd = 1'b0;
        #(3*DIV*CLK_NS);
        rxd = 1'b1;
        #(10*BIT_NS);
        rd(1'b0, 16'h0000, "t5_glitch_rcsr");
        rd(1'b1, 16'h0001, "t5_rbuf_unchanged");

        // read colliding with STOP load
        send(8'h33, 1'b1);
        fork
            send(8'h5A, 1'b1);
            begin
                @(negedge rxd);
                repeat (LOAD_EDGE - 2) @(posedge clk);
                rd(1'b1, 16'h0033, "t6_collision_old");
            end
        join
        rd(1'b0, 16'h0080, "t6_done_kept");
        rd(1'b1, 16'h005A, "t6_new_no_or");

        repeat (5) @(posedge clk);
        chk("sb_empty", 16'(exp_q.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
